// File: rtl/i2c_slave_regbank.sv
// I2C target with a byte register bank (pointer write, auto-increment, streaming reads).
// Optional macro I2C_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_slave_regbank #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h6A,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [7:0]            wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  nack_ptr
);

  localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, RX_PTR, ACK_PTR, RX_DATA, ACK_DATA, TX_DATA, RX_MACK, WAIT_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  scl_sync_q, sda_sync_q;
  logic                    scl_s, sda_s, scl_prev_q, sda_prev_q;
  logic                    scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]              cnt_q, cnt_d;
  logic [7:0]              shift_q, shift_d, tx_q, tx_d;
  logic [PW-1:0]           ptr_q, ptr_d, ptr_inc;
  logic                    oe_q, oe_d, got_q, got_d, mack_q, mack_d;
  logic                    busy_q, busy_d, strobe_q, strobe_d, nack_q, nack_d;
  logic [7:0]              wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic                    we;
  logic [7:0]              bank_q [NUM_REGS];

  // Input synchronisers; idle bus is high so reset them to 1 to avoid false edges
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, sda_hist_q;
  logic       scl_flt_q, sda_flt_q;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[SYNC_STAGES-1]};
      sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[SYNC_STAGES-1]};
      scl_flt_q  <= maj3(scl_hist_q);
      sda_flt_q  <= maj3(sda_hist_q);
    end
  end

  assign scl_s = scl_flt_q;
  assign sda_s = sda_flt_q;
`else
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign ptr_inc   = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    got_d     = got_q;
    mack_d    = mack_q;
    busy_d    = busy_q;
    strobe_d  = 1'b0;
    nack_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    we        = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd7;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, RX_PTR, RX_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q - 4'd1;
          end else if (scl_fall && cnt_q == 4'hF) begin
            if (state_q == ADDR) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d = ACK_ADDR;
                oe_d    = 1'b1;
                busy_d  = 1'b1;
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end else if (state_q == RX_PTR) begin
              if ({1'b0, shift_q} < 9'(NUM_REGS)) begin
                ptr_d   = shift_q[PW-1:0];
                state_d = ACK_PTR;
                oe_d    = 1'b1;
              end else begin
                nack_d  = 1'b1;
                state_d = WAIT_STOP;
              end
            end else begin
              we        = 1'b1;
              strobe_d  = 1'b1;
              wr_addr_d = 8'(ptr_q);
              wr_data_d = shift_q;
              ptr_d     = ptr_inc;
              state_d   = ACK_DATA;
              oe_d      = 1'b1;
            end
          end
        end
        // shift_q[0] still holds R/W here: no bits are shifted during the ACK clock
        ACK_ADDR: if (scl_fall) begin
          cnt_d = 4'd7;
          if (shift_q[0]) begin
            state_d = TX_DATA;
            tx_d    = bank_q[ptr_q];
            oe_d    = ~bank_q[ptr_q][7];
          end else begin
            state_d = RX_PTR;
            oe_d    = 1'b0;
          end
        end
        ACK_PTR, ACK_DATA: if (scl_fall) begin
          state_d = RX_DATA;
          cnt_d   = 4'd7;
          oe_d    = 1'b0;
        end
        TX_DATA: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            state_d = RX_MACK;
            oe_d    = 1'b0;
            got_d   = 1'b0;
          end else begin
            tx_d  = {tx_q[6:0], 1'b0};
            oe_d  = ~tx_q[6];
            cnt_d = cnt_q - 4'd1;
          end
        end
        RX_MACK: begin
          if (scl_rise) begin
            got_d  = 1'b1;
            mack_d = ~sda_s;
            ptr_d  = ptr_inc;
          end else if (scl_fall && got_q) begin
            cnt_d = 4'd7;
            if (mack_q) begin
              state_d = TX_DATA;
              tx_d    = bank_q[ptr_q];
              oe_d    = ~bank_q[ptr_q][7];
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd7;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      got_q     <= 1'b0;
      mack_q    <= 1'b0;
      busy_q    <= 1'b0;
      strobe_q  <= 1'b0;
      nack_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) bank_q[i] <= RESET_VAL;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      got_q     <= got_d;
      mack_q    <= mack_d;
      busy_q    <= busy_d;
      strobe_q  <= strobe_d;
      nack_q    <= nack_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      if (we) bank_q[ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    tx_q    <= tx_d;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_flat[8*i +: 8] = bank_q[i];
  end

  assign sda       = oe_q ? 1'b0 : 1'bz;
  assign wr_strobe = strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign nack_ptr  = nack_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Directed bench for i2c_slave_regbank: bit-banged I2C master, hand-computed expected bank contents.
module tb_i2c_slave_regbank;
  localparam int Q = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         scl = 1'b1;
  logic         m_low = 1'b0;
  wire          sda;
  logic [127:0] regs_flat;
  logic         wr_strobe, busy, nack_ptr;
  logic [7:0]   wr_addr, wr_data;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0, nack_cnt = 0, busy_cyc = 0;
  int s0, n0, b0;
  logic [7:0] exp_bank [16];
  logic       ack;
  logic [7:0] rd;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_regbank #(.SLAVE_ADDR(7'h6A), .NUM_REGS(16), .SYNC_STAGES(2), .RESET_VAL(8'h5A)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .nack_ptr(nack_ptr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe) strobe_cnt++;
    if (nack_ptr) nack_cnt++;
    if (busy) busy_cyc++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_bank(input string tag);
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = exp_bank[i];
    check(tag, regs_flat, f);
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    m_low = 1'b1; wait_q(Q);
    scl = 1'b0;   wait_q(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    m_low = 1'b0; wait_q(Q);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; wait_q(Q);
    scl = 1'b1; wait_q(2*Q);
    scl = 1'b0; wait_q(Q);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    b = sda;      wait_q(Q);
    scl = 1'b0;   wait_q(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic a);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    a = ~b;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~mack);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_bank[i] = 8'h5A;
    repeat (5) @(negedge clk);
    check("reset_bank", regs_flat, {16{8'h5A}});
    check("reset_busy", busy, 0);
    check("reset_strobe", wr_strobe, 0);
    check("reset_nack", nack_ptr, 0);
    check("reset_sda", sda, 1);
    reset = 1'b0;
    wait_q(4);

    // write ptr 3, data 11,22
    s0 = strobe_cnt;
    i2c_start();
    write_byte(8'hD4, ack); check("t1_ack_addr", ack, 1);
    write_byte(8'h03, ack); check("t1_ack_ptr", ack, 1);
    write_byte(8'h11, ack); check("t1_ack_d0", ack, 1);
    write_byte(8'h22, ack); check("t1_ack_d1", ack, 1);
    check("t1_busy", busy, 1);
    i2c_stop();
    wait_q(Q);
    exp_bank[3] = 8'h11; exp_bank[4] = 8'h22;
    check_bank("t1_bank");
    check("t1_strobes", strobe_cnt - s0, 2);
    check("t1_wr_addr", wr_addr, 8'h04);
    check("t1_wr_data", wr_data, 8'h22);
    check("t1_busy_after", busy, 0);

    // pointer wrap 15 -> 0
    i2c_start();
    write_byte(8'hD4, ack); check("t2_ack_addr", ack, 1);
    write_byte(8'h0F, ack); check("t2_ack_ptr", ack, 1);
    write_byte(8'hAA, ack); check("t2_ack_d0", ack, 1);
    write_byte(8'hBB, ack); check("t2_ack_d1", ack, 1);
    i2c_stop();
    wait_q(Q);
    exp_bank[15] = 8'hAA; exp_bank[0] = 8'hBB;
    check_bank("t2_bank");
    check("t2_wr_addr", wr_addr, 8'h00);
    i2c_start();
    write_byte(8'hD5, ack); check("t2_ack_rd", ack, 1);
    read_byte(1'b0, rd); check("t2_ptr_is_1", rd, 8'h5A);
    i2c_stop();

    // fill 5..7 then read 5,6 via repeated START
    i2c_start();
    write_byte(8'hD4, ack);
    write_byte(8'h05, ack);
    write_byte(8'h37, ack);
    write_byte(8'hC8, ack);
    write_byte(8'hE1, ack); check("t3_ack_fill", ack, 1);
    i2c_stop();
    exp_bank[5] = 8'h37; exp_bank[6] = 8'hC8; exp_bank[7] = 8'hE1;
    i2c_start();
    write_byte(8'hD4, ack);
    write_byte(8'h05, ack); check("t3_ack_ptr", ack, 1);
    i2c_start();
    write_byte(8'hD5, ack); check("t3_ack_rd", ack, 1);
    read_byte(1'b1, rd); check("t3_rd0", rd, 8'h37);
    read_byte(1'b0, rd); check("t3_rd1", rd, 8'hC8);
    wait_q(2);
    check("t3_sda_released", sda, 1);
    i2c_stop();
    wait_q(Q);
    check_bank("t3_bank");

    // foreign address
    s0 = strobe_cnt; b0 = busy_cyc;
    i2c_start();
    write_byte(8'hA0, ack); check("t4_no_ack_addr", ack, 0);
    write_byte(8'h03, ack); check("t4_no_ack_b1", ack, 0);
    write_byte(8'h99, ack); check("t4_no_ack_b2", ack, 0);
    i2c_stop();
    wait_q(Q);
    check("t4_busy_cycles", busy_cyc - b0, 0);
    check("t4_strobes", strobe_cnt - s0, 0);
    check_bank("t4_bank");

    // out-of-range pointer
    s0 = strobe_cnt; n0 = nack_cnt;
    i2c_start();
    write_byte(8'hD4, ack); check("t5_ack_addr", ack, 1);
    write_byte(8'h20, ack); check("t5_nack_ptr", ack, 0);
    write_byte(8'h77, ack); check("t5_no_ack_data", ack, 0);
    i2c_stop();
    wait_q(Q);
    check("t5_nack_pulses", nack_cnt - n0, 1);
    check("t5_strobes", strobe_cnt - s0, 0);
    check_bank("t5_bank");
    i2c_start();
    write_byte(8'hD5, ack);
    read_byte(1'b0, rd); check("t5_ptr_kept", rd, 8'hE1);
    i2c_stop();

    // reset while the target holds SDA low for ACK
    i2c_start();
    write_byte(8'hD4, ack);
    write_byte(8'h02, ack);
    for (int i = 7; i >= 0; i--) write_bit(1'b0);
    m_low = 1'b0;
    @(negedge clk);
    check("t6_ack_driven", sda, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_sda_released", sda, 1);
    check("t6_busy", busy, 0);
    for (int i = 0; i < 16; i++) exp_bank[i] = 8'h5A;
    check_bank("t6_bank_reset");
    i2c_stop();
    i2c_start();
    write_byte(8'hD4, ack);
    write_byte(8'h09, ack);
    write_byte(8'h3C, ack); check("t6_ack_after", ack, 1);
    i2c_stop();
    wait_q(Q);
    exp_bank[9] = 8'h3C;
    check_bank("t6_bank_after");

    // 1-cycle SCL glitch before the first address bit
    wait_q(Q);
    m_low = 1'b0; wait_q(Q);
    scl = 1'b1;   wait_q(Q);
    m_low = 1'b1; wait_q(Q);
    scl = 1'b0;   wait_q(Q);
    scl = 1'b1;   @(negedge clk);
    scl = 1'b0;   wait_q(Q);
    write_byte(8'hD4, ack);
`ifdef I2C_GLITCH_FILTER_EN
    check("t7_glitch_filtered", ack, 1);
`else
    check("t7_glitch_counted", ack, 0);
`endif
    i2c_stop();
    wait_q(Q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
